// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the pipelined approximate multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package approx_mul_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_LOWW  = 2'd1,
        MODE_ALL   = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int TILE_W     = 4;
    localparam int STAT_ERR_W = 32;
    localparam int STAT_CNT_W = 16;

    // Decide whether a tile of weight index wsum (= i+j) runs approximate.
    // The reserved mode behaves exactly like the exact mode.
    function automatic logic tile_is_approx(input mode_e mode, input int wsum, input int thr);
        logic res;
        res = 1'b0;
        case (mode)
            MODE_LOWW: res = (wsum < thr);
            MODE_ALL:  res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/approx_mul_tile4.sv
// 4x4 unsigned tile multiplier with optional low-bit rounding approximation.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module approx_mul_tile4
    import approx_mul_pkg::*;
(
    input  logic [TILE_W-1:0]   a,
    input  logic [TILE_W-1:0]   b,
    input  logic                approx,
    output logic [2*TILE_W-1:0] p
);

    logic [2*TILE_W-1:0] exact;

    // True product; approximate form collapses any non-zero low pair to 2'b10.
    always_comb begin
        exact = (2*TILE_W)'(a) * (2*TILE_W)'(b);
        p     = exact;
        if (approx) begin
            p = {exact[2*TILE_W-1:2], (exact[1:0] != 2'b00), 1'b0};
        end
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined W x W approximate unsigned multiplier built from 4x4 tiles; optional error statistics with APPROX_MUL_ERRSTAT_EN.
// Latency: 3 cycles from accepted request to out_valid; throughput 1 per cycle.
// Backpressure: out_ready stalls all three stages; in_ready is combinational from out_ready through the stall chain.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int W = 8,
    parameter int T = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_prod
`ifdef APPROX_MUL_ERRSTAT_EN
    ,
    input  logic                  stat_clr,
    output logic [STAT_ERR_W-1:0] stat_err,
    output logic [STAT_CNT_W-1:0] stat_cnt
`endif
);

    localparam int G  = W / TILE_W;
    localparam int NT = G * G;
    localparam int PW = 2 * W;

    // Stage registers
    logic                s1_valid;
    logic [W-1:0]        s1_a;
    logic [W-1:0]        s1_b;
    mode_e               s1_mode;
    logic                s2_valid;
    logic [2*TILE_W-1:0] s2_tile [NT];
    logic                s3_valid;
    logic [PW-1:0]       s3_prod;

    // Stall chain: a stage loads when empty or when its successor loads
    logic s1_load;
    logic s2_load;
    logic s3_load;

    logic [2*TILE_W-1:0] tile_p [NT];
    logic [PW-1:0]       sum_c;

    // Load enables ripple back from the consumer so a full pipe can drain and accept together.
    always_comb begin
        s3_load  = !s3_valid || out_ready;
        s2_load  = !s2_valid || s3_load;
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load;
    end

    // Tile grid: tile (i,j) multiplies nibble i of a by nibble j of b.
    for (genvar i = 0; i < G; i++) begin : g_row
        for (genvar j = 0; j < G; j++) begin : g_col
            approx_mul_tile4 u_tile (
                .a      (s1_a[TILE_W*i +: TILE_W]),
                .b      (s1_b[TILE_W*j +: TILE_W]),
                .approx (tile_is_approx(s1_mode, i + j, T)),
                .p      (tile_p[i*G + j])
            );
        end
    end

    // Weighted sum of all stage-2 tile results; the full 2W range holds the worst case.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < G; i++) begin
            for (int j = 0; j < G; j++) begin
                sum_c = sum_c + (PW'(s2_tile[i*G + j]) << (TILE_W * (i + j)));
            end
        end
    end

    // Stage 1: capture operands and mode; reserved mode is kept and decoded as exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= MODE_EXACT;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_mode <= mode_e'(in_mode);
            end
        end
    end

    // Stage 2: register every tile result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            for (int k = 0; k < NT; k++) begin
                s2_tile[k] <= '0;
            end
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int k = 0; k < NT; k++) begin
                    s2_tile[k] <= tile_p[k];
                end
            end
        end
    end

    // Stage 3: register the accumulated product; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_prod  <= '0;
        end else if (s3_load) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_prod <= sum_c;
            end
        end
    end

    assign out_valid = s3_valid;
    assign out_prod  = s3_prod;

`ifdef APPROX_MUL_ERRSTAT_EN
    localparam int EW = (PW > STAT_ERR_W) ? PW + 1 : STAT_ERR_W + 1;

    logic [PW-1:0] s2_exact;
    logic [PW-1:0] s3_exact;
    logic [PW-1:0] err_abs;
    logic [EW-1:0] err_sum;
    logic          out_xfer;

    // Exact product rides alongside the approximate one, stage for stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_exact <= '0;
            s3_exact <= '0;
        end else begin
            if (s2_load && s1_valid) begin
                s2_exact <= PW'(s1_a) * PW'(s1_b);
            end
            if (s3_load && s2_valid) begin
                s3_exact <= s2_exact;
            end
        end
    end

    // Absolute error of the result being handed off, and the unsaturated new total.
    always_comb begin
        out_xfer = s3_valid && out_ready;
        err_abs  = (s3_exact >= s3_prod) ? (s3_exact - s3_prod) : (s3_prod - s3_exact);
        err_sum  = EW'(stat_err) + EW'(err_abs);
    end

    // Saturating statistics; a clear takes priority over an update in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_err <= '0;
            stat_cnt <= '0;
        end else if (stat_clr) begin
            stat_err <= '0;
            stat_cnt <= '0;
        end else if (out_xfer) begin
            if (err_sum > EW'({STAT_ERR_W{1'b1}})) begin
                stat_err <= '1;
            end else begin
                stat_err <= err_sum[STAT_ERR_W-1:0];
            end
            if (stat_cnt != '1) begin
                stat_cnt <= stat_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe at W=8, T=1 (stat checks when APPROX_MUL_ERRSTAT_EN is defined).
// Latency: n/a.
// Backpressure: exercised through out_ready stalls and a full-pipe sequence.
module tb_approx_mul_pipe;

    localparam int W = 8;
    localparam int T = 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_prod;
`ifdef APPROX_MUL_ERRSTAT_EN
    logic          stat_clr;
    logic [31:0]   stat_err;
    logic [15:0]   stat_cnt;
`endif

    int total;
    int bad;

    approx_mul_pipe #(.W(W), .T(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
`ifdef APPROX_MUL_ERRSTAT_EN
        ,
        .stat_clr  (stat_clr),
        .stat_err  (stat_err),
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  mode;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: sum over nibble pairs; approximate tiles round any non-multiple of 4 to (p/4)*4+2.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode);
        int unsigned acc;
        int unsigned na;
        int unsigned nb;
        int unsigned p;
        bit          apx;
        logic [31:0] r;
        acc = 0;
        for (int i = 0; i < W/4; i++) begin
            for (int j = 0; j < W/4; j++) begin
                na  = (32'(a) >> (4*i)) % 16;
                nb  = (32'(b) >> (4*j)) % 16;
                p   = na * nb;
                apx = (mode == 2'd2) || (mode == 2'd1 && (i + j) < T);
                if (apx && (p % 4) != 0) p = p - (p % 4) + 2;
                acc = acc + (p << (4*(i+j)));
            end
        end
        r = acc;
        return r[15:0];
    endfunction

    // Issue one request into an empty pipe and measure edges until out_valid.
    task automatic send_and_wait(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                                 output int lat, output logic [15:0] prod);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_mode = m; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat  = 99;
        prod = 16'hxxxx;
        for (int c = 1; c <= 8; c++) begin
            if (out_valid) begin
                lat  = c;
                prod = out_prod;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    logic [15:0] expq [$];
    logic [7:0]  bpa [5];
    logic [7:0]  bpb [5];
    logic [1:0]  bpm [5];

    initial begin
        int          lat;
        logic [15:0] prod;
        logic        held_vld;
        logic [15:0] held_prod;
        int          idx;
        int          outs;
        bit          rdy_all;
        bit          stale;

        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b0;
`ifdef APPROX_MUL_ERRSTAT_EN
        stat_clr = 1'b0;
`endif

        tbl[0] = '{8'hFF, 8'hFF, 2'd2, 16'hFF22};
        tbl[1] = '{8'hFF, 8'hFF, 2'd0, 16'hFE01};
        tbl[2] = '{8'hFF, 8'hFF, 2'd1, 16'hFE02};
        tbl[3] = '{8'hFF, 8'hFF, 2'd3, 16'hFE01};
        tbl[4] = '{8'h03, 8'h03, 2'd2, 16'h000A};
        tbl[5] = '{8'h02, 8'h01, 2'd2, 16'h0002};
        tbl[6] = '{8'h00, 8'h5A, 2'd2, 16'h0000};
        tbl[7] = '{8'h12, 8'h34, 2'd1, 16'h03A8};
        tbl[8] = '{8'h11, 8'h11, 2'd1, 16'h0122};
        tbl[9] = '{8'h11, 8'h11, 2'd2, 16'h0242};

        // Reset state
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_prod", 64'(out_prod), 64'd0);
`ifdef APPROX_MUL_ERRSTAT_EN
        check("rst_stat_err", 64'(stat_err), 64'd0);
        check("rst_stat_cnt", 64'(stat_cnt), 64'd0);
`endif
        #10 rst_n = 1'b1;

        // Directed vectors: value and 3-cycle latency
        foreach (tbl[k]) begin
            send_and_wait(tbl[k].a, tbl[k].b, tbl[k].mode, lat, prod);
            check($sformatf("tbl%0d_lat", k), 64'(lat), 64'd3);
            check($sformatf("tbl%0d_prod", k), 64'(prod), 64'(tbl[k].exp));
            check($sformatf("tbl%0d_model", k), 64'(prod), 64'(model(tbl[k].a, tbl[k].b, tbl[k].mode)));
        end

        // Full-rate streaming: in_ready must stay high with out_ready high
        @(posedge clk); #1;
        out_ready = 1'b1;
        rdy_all = 1'b1;
        outs = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            in_a = 8'(c * 37 + 5); in_b = 8'(c * 11 + 200); in_mode = 2'(c);
            #3;
            if (in_valid && !in_ready) rdy_all = 1'b0;
            if (out_valid) begin
                outs++;
                if (expq.size() != 0) check("stream_prod", 64'(out_prod), 64'(expq.pop_front()));
            end
            if (in_valid && in_ready) expq.push_back(model(in_a, in_b, in_mode));
            @(posedge clk); #1;
        end
        check("stream_rdy", 64'(rdy_all), 64'd1);
        check("stream_count", 64'(outs), 64'd8);
        expq.delete();
        in_valid = 1'b0;

        // Randomized traffic with random backpressure against the model
        held_vld = 1'b0; held_prod = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (held_vld) check("stall_hold", {out_valid, out_prod}, {1'b1, held_prod});
            if (cyc < 300) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 2'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) check("rand_spurious", 64'd1, 64'd0);
                else check("rand_prod", 64'(out_prod), 64'(expq.pop_front()));
            end
            held_vld  = out_valid && !out_ready;
            held_prod = out_prod;
            if (in_valid && in_ready) expq.push_back(model(in_a, in_b, in_mode));
        end
        check("rand_drain", 64'(expq.size()), 64'd0);
        expq.delete();

        // Backpressure: offer 5 with out_ready low, only 3 fit
        for (int k = 0; k < 5; k++) begin
            bpa[k] = 8'(8'hF0 - k * 9); bpb[k] = 8'(k * 29 + 7); bpm[k] = 2'(k);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_a = bpa[idx]; in_b = bpb[idx]; in_mode = bpm[idx];
            #3;
            if (in_ready) begin
                expq.push_back(model(in_a, in_b, in_mode));
                idx++;
            end
            @(posedge clk); #1;
        end
        check("bp_accepted", 64'(idx), 64'd3);
        in_valid = 1'b1; in_a = bpa[idx]; in_b = bpb[idx]; in_mode = bpm[idx];
        #1;
        check("bp_full_rdy", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(in_ready), 64'd1);
        outs = 0;
        for (int c = 0; c < 30 && (outs < 5); c++) begin
            if (idx < 5) begin
                in_valid = 1'b1; in_a = bpa[idx]; in_b = bpb[idx]; in_mode = bpm[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                outs++;
                if (expq.size() == 0) check("bp_spurious", 64'd1, 64'd0);
                else check($sformatf("bp_prod%0d", outs), 64'(out_prod), 64'(expq.pop_front()));
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(in_a, in_b, in_mode));
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_outs", 64'(outs), 64'd5);
        expq.delete();

        // Reset mid-flight: two results parked, then a sub-cycle reset pulse
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_mode = 2'd0;
        @(posedge clk); #1;
        in_a = 8'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        #3 rst_n = 1'b0;
        #2;
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_prod", 64'(out_prod), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("mid_no_stale", 64'(stale), 64'd0);

`ifdef APPROX_MUL_ERRSTAT_EN
        // Statistics: four all-approximate FFxFF results, error 0x121 each
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("stat_clr_cnt", 64'(stat_cnt), 64'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_mode = 2'd2;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        check("stat_err4", 64'(stat_err), 64'h484);
        check("stat_cnt4", 64'(stat_cnt), 64'd4);

        // Clear coincident with a handshake wins
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'h33; in_b = 8'h99; in_mode = 2'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stat_clr_setup_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1; stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        check("stat_clr_xfer_err", 64'(stat_err), 64'd0);
        check("stat_clr_xfer_cnt", 64'(stat_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
